adler32_check: RTL
==================

// Module: adler32_check
// PURPOSE
//   Receive-side Adler-32 verifier: consumes a byte frame = payload followed by a 4-byte
//   Adler-32 trailer ({B,A}, MSB first), recomputes the checksum over the payload only,
//   and reports pass/fail per frame. Sits on the byte stream downstream of the link,
//   as the counterpart to the transmit-side checksum accumulator.
// PARAMETERS
//   none (modulus 65521 and trailer length 4 are fixed constants in adler32_pkg)
// PORTS
//   clk         in   1   clock, all state on rising edge
//   rst         in   1   asynchronous, active-high reset
//   in_valid    in   1   byte present on in_data
//   in_ready    out  1   byte accepted when in_valid && in_ready
//   in_data     in   8   frame byte (payload, then 4 trailer bytes)
//   in_last     in   1   marks final trailer byte of the frame
//   res_valid   out  1   result held until accepted
//   res_ready   in   1   consumer accepts result
//   res_pass    out  1   1 = computed checksum equals trailer
//   res_short   out  1   1 = frame shorter than 4 bytes (res_pass forced 0)
//   res_calc    out  32  computed {B,A} over payload
// BEHAVIOUR
//   - Reset: in_ready=1, res_valid=0, res_pass=0, res_short=0, res_calc=0; A=1, B=0,
//     delay line cleared, state IDLE. Reset mid-frame discards the partial frame.
//   - Delay line: 4-byte shift register; each accepted byte shifts in; the byte shifted
//     out (5th newest) is payload and is fed to the accumulator:
//     A' = (A + byte) mod 65521; B' = (B + A') mod 65521.
//   - Modular add: 17-bit sum, subtract 65521 when sum >= 65521; result always < 65521.
//   - FSM: IDLE (0 bytes) -> FILL on first byte; FILL counts 1..3 buffered bytes -> RUN when
//     4th byte shifts in; RUN accumulates on every accepted byte. Any accepted in_last
//     returns to IDLE and re-inits A=1, B=0, count=0 in the same edge.
//   - in_last beat in RUN: final A/B include the byte shifting out this beat; compare
//     {dly[2],dly[1],dly[0],in_data} (oldest = B[15:8]) against {B',A'}.
//   - in_last beat in IDLE/FILL (frame < 4 bytes): res_short=1, res_pass=0, res_calc=0.
//   - Latency: result registered; res_valid rises the cycle after the in_last beat.
//   - res_valid holds with stable res_* until res_valid && res_ready; then clears unless
//     a new result is registered on the same edge (new result wins).
//   - in_ready = !(res_valid && !res_ready): input stalls only while an unaccepted result
//     is pending; a next frame's bytes may be accepted while the result is consumed.
//   - No upper frame-length limit; A/B never overflow due to per-byte reduction.
// CONFIGURATION
//   ADLER32_CHECK_ERRCNT_EN defined: extra port err_count out 16, reset 0, +1 on each
//     registered result with res_pass=0 (short frames included), saturates at 16'hFFFF.
//   Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   adler32_pkg: ADLER_MOD = 16'd65521, ADLER_TRAILER_LEN = 4, state enum
//     {IDLE, FILL, RUN}, 32-bit checksum typedef.
//   Sub-module adler32_mod_add (16-bit a + b mod 65521, combinational); two instances
//     chained for A' and B'.
// TESTING
//   1. "Wikipedia" + 11 E6 03 98, res_ready=1 -> res_pass=1, res_calc=32'h11E60398.
//   2. Empty payload, trailer 00 00 00 01 -> res_pass=1, res_short=0, res_calc=32'h00000001.
//   3. "Wikipedia" with one payload bit flipped, same trailer -> res_pass=0; err_count=1 with EN.
//   4. 400 x 8'hFF + 22 90 8E 80 -> res_pass=1, res_calc=32'h22908E80 (modulo wrap on A and B).
//   5. 2-byte frame with in_last -> res_short=1, res_pass=0; following good frame passes.
//   6. Hold res_ready=0 after frame 1 -> in_ready=0, res_* stable; raise res_ready -> in_ready=1
//      same cycle; back-to-back frame 2 verifies; assert rst mid-frame 3 -> state IDLE, res_valid=0,
//      next frame verifies correctly.

Source files
------------

// File: rtl/adler32_pkg.sv
// Shared constants and types for the receive-side Adler-32 verifier.
// Optional build macro used by adler32_check: ADLER32_CHECK_ERRCNT_EN.
package adler32_pkg;

    localparam logic [15:0] ADLER_MOD         = 16'd65521;
    localparam int          ADLER_TRAILER_LEN = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } state_t;

    typedef logic [31:0] checksum_t;

endpackage

// File: rtl/adler32_mod_add.sv
// Combinational 16-bit addition modulo 65521; both operands must already be < 65521.
module adler32_mod_add
    import adler32_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [16:0] raw_s;

    // One conditional subtraction suffices because the raw sum is below 2*65521.
    always_comb begin
        raw_s = {1'b0, a} + {1'b0, b};
        if (raw_s >= {1'b0, ADLER_MOD}) begin
            sum = raw_s[15:0] - ADLER_MOD;
        end else begin
            sum = raw_s[15:0];
        end
    end

endmodule

// File: rtl/adler32_check.sv
// Receive-side Adler-32 frame verifier: payload followed by a 4-byte {B,A} trailer.
// Define ADLER32_CHECK_ERRCNT_EN to add the saturating err_count output.
module adler32_check
    import adler32_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        res_valid,
    input  logic        res_ready,
    output logic        res_pass,
    output logic        res_short,
    output logic [31:0] res_calc
`ifdef ADLER32_CHECK_ERRCNT_EN
    ,
    output logic [15:0] err_count
`endif
);

    localparam logic [1:0] FILL_LAST = 2'(ADLER_TRAILER_LEN - 1);

    state_t          state_r;
    state_t          state_s;
    logic [1:0]      cnt_r;
    logic [1:0]      cnt_s;
    logic [15:0]     a_r;
    logic [15:0]     a_s;
    logic [15:0]     b_r;
    logic [15:0]     b_s;
    logic [3:0][7:0] dly_r;

    logic [15:0]     a_acc_s;
    logic [15:0]     b_acc_s;
    logic [15:0]     a_fin_s;
    logic [15:0]     b_fin_s;
    logic            in_fire_s;
    logic            res_fire_s;
    logic            new_res_s;
    logic            short_s;
    logic            pass_s;
    checksum_t       calc_s;
    checksum_t       trailer_s;

    assign in_ready   = !(res_valid && !res_ready);
    assign in_fire_s  = in_valid && in_ready;
    assign res_fire_s = res_valid && res_ready;
    assign new_res_s  = in_fire_s && in_last;

    // The byte leaving the delay line is the only one known to be payload.
    adler32_mod_add u_add_a (
        .a   (a_r),
        .b   ({8'h00, dly_r[3]}),
        .sum (a_acc_s)
    );

    adler32_mod_add u_add_b (
        .a   (b_r),
        .b   (a_acc_s),
        .sum (b_acc_s)
    );

    // Next-state and accumulator update for the frame tracking FSM.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        a_s     = a_r;
        b_s     = b_r;
        if (in_fire_s) begin
            if (in_last) begin
                state_s = IDLE;
                cnt_s   = 2'd0;
                a_s     = 16'd1;
                b_s     = 16'd0;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_s = FILL;
                        cnt_s   = 2'd1;
                    end
                    FILL: begin
                        if (cnt_r == FILL_LAST) begin
                            state_s = RUN;
                            cnt_s   = cnt_r;
                        end else begin
                            state_s = FILL;
                            cnt_s   = cnt_r + 2'd1;
                        end
                    end
                    RUN: begin
                        a_s = a_acc_s;
                        b_s = b_acc_s;
                    end
                    default: begin
                        state_s = IDLE;
                        cnt_s   = 2'd0;
                    end
                endcase
            end
        end else begin
            state_s = state_r;
        end
    end

    // Verdict for a frame ending on this beat; a 4-byte frame reaches here from FILL with no payload.
    always_comb begin
        short_s   = (state_r == IDLE) || ((state_r == FILL) && (cnt_r != FILL_LAST));
        trailer_s = {dly_r[2], dly_r[1], dly_r[0], in_data};
        if (state_r == RUN) begin
            a_fin_s = a_acc_s;
            b_fin_s = b_acc_s;
        end else begin
            a_fin_s = a_r;
            b_fin_s = b_r;
        end
        if (short_s) begin
            calc_s = 32'h0000_0000;
            pass_s = 1'b0;
        end else begin
            calc_s = {b_fin_s, a_fin_s};
            pass_s = (calc_s == trailer_s);
        end
    end

    // FSM state register and running checksum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 2'd0;
            a_r     <= 16'd1;
            b_r     <= 16'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            a_r     <= a_s;
            b_r     <= b_s;
        end
    end

    // Four-byte delay line holding the candidate trailer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_r <= 32'h0000_0000;
        end else if (in_fire_s) begin
            dly_r <= {dly_r[2:0], in_data};
        end
    end

    // Result holding register; a newly registered result wins over a same-edge hand-off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_pass  <= 1'b0;
            res_short <= 1'b0;
            res_calc  <= 32'h0000_0000;
        end else if (new_res_s) begin
            res_valid <= 1'b1;
            res_pass  <= pass_s;
            res_short <= short_s;
            res_calc  <= calc_s;
        end else if (res_fire_s) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ADLER32_CHECK_ERRCNT_EN
    // Saturating count of failed frames, short frames included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_count <= 16'h0000;
        end else if (new_res_s && !pass_s && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'h0001;
        end
    end
`endif

endmodule
